// File: rtl/score_bcd_writer.sv
// BCD point counter that mirrors its four digits into regfile entries, using idle write-port cycles.
// Build option: define SCORE_SATURATE_EN to hold the score at 9999 instead of wrapping to 0000.
module score_bcd_writer #(
  parameter int BASE_REG = 1,
  parameter int PEND_W   = 3
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        point_in,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_writeReg,
  input  logic [31:0] cpu_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [15:0] score_bcd,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INC  = 3'd1,
    S_W0   = 3'd2,
    S_W1   = 3'd3,
    S_W2   = 3'd4,
    S_W3   = 3'd5
  } state_t;

  localparam logic [4:0]  BASE_IDX = 5'(BASE_REG);
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_score;
  logic [15:0]         w_score_inc;
  logic [PEND_W-1:0]   r_pend;
  logic [PEND_W-1:0]   w_pend_nxt;
  logic                r_busy;
  logic                r_overflow;
  logic                w_take;
  logic                w_pend_inc;
  logic                w_digit_state;
  logic [1:0]          w_digit_idx;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = 16'h0000;
    carry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (carry && (v[4*k +: 4] == 4'd9)) begin
        res[4*k +: 4] = 4'd0;
        carry         = 1'b1;
      end else if (carry) begin
        res[4*k +: 4] = v[4*k +: 4] + 4'd1;
        carry         = 1'b0;
      end else begin
        res[4*k +: 4] = v[4*k +: 4];
        carry         = 1'b0;
      end
    end
    return res;
  endfunction

`ifdef SCORE_SATURATE_EN
  assign w_score_inc = (r_score == SCORE_MAX) ? SCORE_MAX : bcd_inc(r_score);
`else
  assign w_score_inc = bcd_inc(r_score);
`endif

  // A pulse arriving while idle starts the sequence directly instead of parking in the counter.
  assign w_take     = (r_state == S_IDLE) && ((r_pend != '0) || point_in);
  assign w_pend_inc = point_in && (!(&r_pend) || w_take);

  // Pending-point counter next value
  always_comb begin
    w_pend_nxt = r_pend;
    case ({w_pend_inc, w_take})
      2'b10:   w_pend_nxt = r_pend + PEND_W'(1);
      2'b01:   w_pend_nxt = r_pend - PEND_W'(1);
      default: w_pend_nxt = r_pend;
    endcase
  end

  // FSM next-state: digit states only advance on cycles the processor leaves the port free
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_take ? S_INC : S_IDLE;
      S_INC:   w_state_nxt = S_W0;
      S_W0:    w_state_nxt = cpu_we ? S_W0 : S_W1;
      S_W1:    w_state_nxt = cpu_we ? S_W1 : S_W2;
      S_W2:    w_state_nxt = cpu_we ? S_W2 : S_W3;
      S_W3:    w_state_nxt = cpu_we ? S_W3 : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Digit index for the current write state
  always_comb begin
    w_digit_state = 1'b1;
    w_digit_idx   = 2'd0;
    case (r_state)
      S_W0:    w_digit_idx = 2'd0;
      S_W1:    w_digit_idx = 2'd1;
      S_W2:    w_digit_idx = 2'd2;
      S_W3:    w_digit_idx = 2'd3;
      default: w_digit_state = 1'b0;
    endcase
  end

  // Write-port mux: processor first, then digit writes, never during reset
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = cpu_writeReg;
    data_writeReg    = cpu_data;
    if (cpu_we) begin
      ctrl_writeEnable = 1'b1;
    end else if (w_digit_state && !ctrl_reset) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = BASE_IDX + {3'b000, w_digit_idx};
      data_writeReg    = {28'h0000000, r_score[4*w_digit_idx +: 4]};
    end else begin
      ctrl_writeEnable = 1'b0;
    end
  end

  // State, score, pending counter and status flags
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_state    <= S_IDLE;
      r_score    <= 16'h0000;
      r_pend     <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_busy     <= (w_state_nxt != S_IDLE) || (w_pend_nxt != '0);
      r_overflow <= (w_state_nxt == S_INC) && (r_score == SCORE_MAX);
      if (r_state == S_INC) begin
        r_score <= w_score_inc;
      end else begin
        r_score <= r_score;
      end
    end
  end

  assign score_bcd = r_score;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_score_bcd_writer.sv
// Scoreboard bench for score_bcd_writer: expected regfile writes are queued by the stimulus
// and popped by a monitor on every enabled write-port cycle.
module tb_score_bcd_writer;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        point_in;
  logic        cpu_we;
  logic [4:0]  cpu_writeReg;
  logic [31:0] cpu_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [15:0] score_bcd;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
  logic [15:0] exp_ovf_score;
  int          n;

  score_bcd_writer dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .point_in         (point_in),
    .cpu_we           (cpu_we),
    .cpu_writeReg     (cpu_writeReg),
    .cpu_data         (cpu_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .score_bcd        (score_bcd),
    .busy             (busy),
    .overflow         (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic push_digits(input logic [15:0] s);
    for (int k = 0; k < 4; k++) begin
      push_wr(5'(1 + k), {28'h0000000, s[4*k +: 4]});
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_point(input logic [15:0] new_score);
    point_in = 1'b1;
    push_digits(new_score);
    tick;
    point_in = 1'b0;
    repeat (5) tick;
  endtask

  // Monitor: every enabled write must match the head of the expected queue
  always @(negedge clock) begin
    if (ctrl_writeEnable === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected actual reg=%0d data=%h required=no write", ctrl_writeReg, data_writeReg);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ctrl_writeReg, data_writeReg} !== mon_e) begin
          bad++;
          $display("FAIL wr actual reg=%0d data=%h required reg=%0d data=%h",
                   ctrl_writeReg, data_writeReg, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
`ifdef SCORE_SATURATE_EN
    exp_ovf_score = 16'h9999;
`else
    exp_ovf_score = 16'h0000;
`endif
    ctrl_reset   = 1'b1;
    point_in     = 1'b0;
    cpu_we       = 1'b0;
    cpu_writeReg = 5'd0;
    cpu_data     = 32'h0;

    // Reset state with processor passthrough
    tick;
    cpu_we = 1'b1; cpu_writeReg = 5'd5; cpu_data = 32'hA5A50001;
    push_wr(5'd5, 32'hA5A50001);
    sample;
    check("rst_score", {16'h0, score_bcd}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    tick;
    cpu_we = 1'b0; cpu_writeReg = 5'd3; cpu_data = 32'h00C0FFEE;
    sample;
    check("idle_we", {31'h0, ctrl_writeEnable}, 32'h0);
    check("idle_reg", {27'h0, ctrl_writeReg}, 32'd3);
    check("idle_data", data_writeReg, 32'h00C0FFEE);
    tick;
    ctrl_reset = 1'b0;
    tick;

    // Single point: INC at t+1, digits t+2..t+5, busy low at t+6
    point_in = 1'b1;
    push_digits(16'h0001);
    tick;
    point_in = 1'b0;
    sample;
    check("p1_busy_t1", {31'h0, busy}, 32'h1);
    check("p1_we_t1", {31'h0, ctrl_writeEnable}, 32'h0);
    repeat (4) tick;
    sample;
    check("p1_busy_t5", {31'h0, busy}, 32'h1);
    tick;
    sample;
    check("p1_busy_t6", {31'h0, busy}, 32'h0);
    check("p1_score", {16'h0, score_bcd}, 32'h0001);

    // Count to 9, then carry into tens
    for (int i = 2; i <= 10; i++) do_point(to_bcd(i));
    sample;
    check("carry_score", {16'h0, score_bcd}, 32'h0010);

    // Processor steals the port for 3 cycles while in W1
    point_in = 1'b1;
    push_wr(5'd1, 32'd1);
    push_wr(5'd7, 32'hDEADBEEF);
    push_wr(5'd7, 32'hDEADBEEF);
    push_wr(5'd7, 32'hDEADBEEF);
    push_wr(5'd2, 32'd1);
    push_wr(5'd3, 32'd0);
    push_wr(5'd4, 32'd0);
    tick;
    point_in = 1'b0;
    tick;
    tick;
    cpu_we = 1'b1; cpu_writeReg = 5'd7; cpu_data = 32'hDEADBEEF;
    repeat (3) tick;
    cpu_we = 1'b0;
    tick;
    tick;
    sample;
    check("stall_busy_t8", {31'h0, busy}, 32'h1);
    tick;
    sample;
    check("stall_busy_t9", {31'h0, busy}, 32'h0);
    check("stall_score", {16'h0, score_bcd}, 32'h0011);

    // Reset during W2 abandons the sequence, processor write still passes
    point_in = 1'b1;
    push_wr(5'd1, 32'd2);
    push_wr(5'd2, 32'd1);
    tick;
    point_in = 1'b0;
    repeat (3) tick;
    ctrl_reset = 1'b1; cpu_we = 1'b1; cpu_writeReg = 5'd9; cpu_data = 32'h12345678;
    push_wr(5'd9, 32'h12345678);
    tick;
    ctrl_reset = 1'b0; cpu_we = 1'b0;
    sample;
    check("rstw2_busy", {31'h0, busy}, 32'h0);
    check("rstw2_score", {16'h0, score_bcd}, 32'h0);
    check("rstw2_we", {31'h0, ctrl_writeEnable}, 32'h0);
    repeat (6) tick;

    // Ten back-to-back pulses with the port held by the processor: pending caps at 7
    cpu_we = 1'b1; cpu_writeReg = 5'd7; cpu_data = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      point_in = 1'b1;
      push_wr(5'd7, 32'hDEADBEEF);
      tick;
    end
    point_in = 1'b0;
    cpu_we   = 1'b0;
    for (int i = 1; i <= 8; i++) push_digits(to_bcd(i));
    n = 0;
    sample;
    while (busy && n < 200) begin
      tick;
      sample;
      n++;
    end
    check("sat_drain", {31'h0, busy}, 32'h0);
    check("sat_score", {16'h0, score_bcd}, 32'h0008);

    // Run up to 9999
    tick;
    for (int i = 9; i <= 9999; i++) do_point(to_bcd(i));
    sample;
    check("max_score", {16'h0, score_bcd}, 32'h9999);
    check("max_ovf_low", {31'h0, overflow}, 32'h0);

    // Increment past 9999: overflow pulses during INC only
    tick;
    point_in = 1'b1;
    push_digits(exp_ovf_score);
    tick;
    point_in = 1'b0;
    sample;
    check("ovf_pulse", {31'h0, overflow}, 32'h1);
    tick;
    sample;
    check("ovf_clear", {31'h0, overflow}, 32'h0);
    repeat (4) tick;
    sample;
    check("ovf_busy", {31'h0, busy}, 32'h0);
    check("ovf_score", {16'h0, score_bcd}, {16'h0, exp_ovf_score});

    repeat (3) tick;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
